// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on input and output.
// Shifts run one bit per cycle; MUL is an iterative shift-add; results are held until taken.
module alu_seq #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpShl = 3'b101;
  localparam logic [2:0] OpShr = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e             r_state, w_state_d;
  logic [2:0]         r_op, w_op_d;
  logic [CW-1:0]      r_cnt, w_cnt_d;
  logic [2*WIDTH-1:0] r_acc, w_acc_d;
  logic [2*WIDTH-1:0] r_mcand, w_mcand_d;
  logic [WIDTH-1:0]   r_mplier, w_mplier_d;
  logic [WIDTH-1:0]   r_y, w_y_d;
  logic               r_carry, w_carry_d;
  logic               r_zero, w_zero_d;
  logic               r_neg, w_neg_d;
  logic               r_ovf, w_ovf_d;

  logic [WIDTH:0]     w_sum, w_diff;
  logic [2*WIDTH-1:0] w_acc_next;
  logic               w_y_upd;

  assign w_sum      = {1'b0, A} + {1'b0, B};
  assign w_diff     = {1'b0, A} - {1'b0, B};
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_state_d  = r_state;
    w_op_d     = r_op;
    w_cnt_d    = r_cnt;
    w_acc_d    = r_acc;
    w_mcand_d  = r_mcand;
    w_mplier_d = r_mplier;
    w_y_d      = r_y;
    w_carry_d  = r_carry;
    w_ovf_d    = r_ovf;
    w_y_upd    = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_op_d    = opcode;
          w_y_upd   = 1'b1;
          w_carry_d = 1'b0;
          w_ovf_d   = 1'b0;
          w_state_d = StDone;
          unique case (opcode)
            OpAdd: begin
              w_y_d     = w_sum[WIDTH-1:0];
              w_carry_d = w_sum[WIDTH];
              w_ovf_d   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OpSub: begin
              w_y_d     = w_diff[WIDTH-1:0];
              w_carry_d = w_diff[WIDTH];
              w_ovf_d   = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OpAnd: w_y_d = A & B;
            OpOr:  w_y_d = A | B;
            OpXor: w_y_d = A ^ B;
            OpShl, OpShr: begin
              w_y_d   = A;
              w_cnt_d = CW'(B[SHW-1:0]);
              if (B[SHW-1:0] != '0) w_state_d = StBusy;
            end
            OpMul: begin
              // Y keeps its old value until the product is complete.
              w_y_upd    = 1'b0;
              w_y_d      = r_y;
              w_acc_d    = '0;
              w_mcand_d  = {{WIDTH{1'b0}}, A};
              w_mplier_d = B;
              w_cnt_d    = CW'(WIDTH);
              w_state_d  = StBusy;
            end
            default: ;
          endcase
        end
      end
      StBusy: begin
        w_cnt_d = r_cnt - CW'(1);
        if (r_op == OpMul) begin
          w_acc_d    = w_acc_next;
          w_mcand_d  = r_mcand << 1;
          w_mplier_d = r_mplier >> 1;
          if (r_cnt == CW'(1)) begin
            w_y_d     = w_acc_next[WIDTH-1:0];
            w_carry_d = |w_acc_next[2*WIDTH-1:WIDTH];
            w_y_upd   = 1'b1;
            w_state_d = StDone;
          end
        end else begin
          w_y_upd = 1'b1;
          if (r_op == OpShl) begin
            w_carry_d = r_y[WIDTH-1];
            w_y_d     = r_y << 1;
          end else begin
            w_carry_d = r_y[0];
            w_y_d     = r_y >> 1;
          end
          if (r_cnt == CW'(1)) w_state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    // zero/negative track Y only when Y is written, so reset leaves them at 0.
    w_zero_d = w_y_upd ? (w_y_d == '0) : r_zero;
    w_neg_d  = w_y_upd ? w_y_d[WIDTH-1] : r_neg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_op     <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_y      <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_op     <= w_op_d;
      r_cnt    <= w_cnt_d;
      r_acc    <= w_acc_d;
      r_mcand  <= w_mcand_d;
      r_mplier <= w_mplier_d;
      r_y      <= w_y_d;
      r_carry  <= w_carry_d;
      r_zero   <= w_zero_d;
      r_neg    <= w_neg_d;
      r_ovf    <= w_ovf_d;
    end
  end

  assign in_ready  = (r_state == StIdle) && !rst;
  assign out_valid = (r_state == StDone);
  assign Y         = r_y;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign negative  = r_neg;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: directed plan cases, backpressure, mid-op reset, random ops
// checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] A, B;
  logic [2:0]   opcode;
  logic         out_valid, out_ready;
  logic [W-1:0] Y;
  logic         carry, zero, negative, overflow;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .opcode   (opcode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Y        (Y),
    .carry    (carry),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning.
  task automatic model(input int a, input int b, input int op,
                       output int y, output int c, output int v, output int lat);
    int n, p, sa, sb, s;
    n  = b % W;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = 0; v = 0; lat = 1;
    case (op)
      0: begin p = a + b; y = p % 256; c = (p > 255); s = sa + sb; v = (s > 127 || s < -128); end
      1: begin y = (a - b + 256) % 256; c = (a < b); s = sa - sb; v = (s > 127 || s < -128); end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: begin y = (a * (1 << n)) % 256; c = (n == 0) ? 0 : (a >> (W - n)) % 2; lat = 1 + n; end
      6: begin y = a >> n; c = (n == 0) ? 0 : (a >> (n - 1)) % 2; lat = 1 + n; end
      default: begin p = a * b; y = p % 256; c = (p > 255); lat = 1 + W; end
    endcase
  endtask

  task automatic start_op(input int a, input int b, input int op);
    int g = 0;
    while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
    @(negedge clk);
    A = W'(a); B = W'(b); opcode = 3'(op); in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input int a, input int b, input int op);
    int ey, ec, ev, el, lat;
    model(a, b, op, ey, ec, ev, el);
    start_op(a, b, op);
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check({tag, ".lat"}, lat, el);
    check({tag, ".y"}, int'(Y), ey);
    check({tag, ".carry"}, int'(carry), ec);
    check({tag, ".zero"}, int'(zero), int'(ey == 0));
    check({tag, ".neg"}, int'(negative), (ey >> 7) % 2);
    check({tag, ".ovf"}, int'(overflow), ev);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, ".in_ready_after"}, int'(in_ready), 1);
    check({tag, ".out_valid_after"}, int'(out_valid), 0);
  endtask

  initial begin
    int ey, ec, ev, el, lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; opcode = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.y", int'(Y), 0);
    check("rst.flags", int'({carry, zero, negative, overflow}), 0);
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.in_ready", int'(in_ready), 0);
    @(negedge clk) rst = 1'b0;
    #1;
    check("post_rst.in_ready", int'(in_ready), 1);
    check("post_rst.out_valid", int'(out_valid), 0);

    run_op("add_ff_01", 8'hFF, 8'h01, 0);
    run_op("add_7f_01", 8'h7F, 8'h01, 0);
    run_op("sub_03_01", 8'h03, 8'h01, 1);
    run_op("sub_01_03", 8'h01, 8'h03, 1);
    run_op("sub_80_01", 8'h80, 8'h01, 1);
    run_op("and", 8'h3C, 8'h0F, 2);
    run_op("or", 8'h3C, 8'h0F, 3);
    run_op("xor", 8'h3C, 8'h0F, 4);
    run_op("shl_3", 8'h81, 8'd3, 5);
    run_op("shr_1", 8'h81, 8'd1, 6);
    run_op("shl_0", 8'h81, 8'd0, 5);
    run_op("shr_7", 8'hC0, 8'd7, 6);
    run_op("mul_10_11", 8'h10, 8'h11, 7);
    run_op("mul_0f_03", 8'h0F, 8'h03, 7);
    run_op("mul_ff_ff", 8'hFF, 8'hFF, 7);

    // Backpressure: result held, no accept while DONE.
    model(8'h7F, 8'h01, 0, ey, ec, ev, el);
    start_op(8'h7F, 8'h01, 0);
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bp.lat", lat, el);
    @(negedge clk);
    A = 8'h05; B = 8'h05; opcode = 3'd2; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.hold_y", int'(Y), ey);
      check("bp.hold_flags", int'({carry, overflow, negative, zero}), (ec << 3) | (ev << 2) | 2);
      check("bp.in_ready", int'(in_ready), 0);
      check("bp.out_valid", int'(out_valid), 1);
    end
    @(negedge clk) in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check("bp.in_ready_after", int'(in_ready), 1);
    check("bp.y_after", int'(Y), ey);

    // Reset in the middle of a multiply.
    start_op(8'h10, 8'h11, 7);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    #1 check("mrst.in_ready_in_rst", int'(in_ready), 0);
    @(posedge clk); #1;
    check("mrst.y", int'(Y), 0);
    check("mrst.flags", int'({carry, zero, negative, overflow}), 0);
    check("mrst.out_valid", int'(out_valid), 0);
    @(negedge clk) rst = 1'b0;
    #1 check("mrst.in_ready", int'(in_ready), 1);
    run_op("mrst.add", 8'h12, 8'h34, 0);

    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
